if_stage: RTL and testbench
===========================

Name: if_stage

Overview:
Instruction-fetch stage of the 5-stage pipeline. Owns the PC register, drives the instruction memory, and captures each fetched word into the IF/ID pipeline register for the decode stage. It applies stalls from hazard detection and redirects (taken branch, B/BR) from the execute stage. It also detects HLT (opcode 4'hF) to freeze fetch.

Parameters:
RESET_PC, 16'h0000, PC value loaded on reset
NOP_INSTR, 16'h0000, instruction word placed in IF/ID on bubble or flush
HLT_OPCODE, 4'hF, opcode treated as halt

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous, active-low reset
stall  input  1  hazard unit: hold PC and IF/ID
redirect  input  1  execute stage: taken branch, flush IF/ID and load redirect_pc
redirect_pc  input  16  branch/jump target
imem_data  input  16  instruction word at imem_addr, combinational read, same cycle
imem_addr  output  16  fetch address, equals pc
imem_en  output  1  instruction memory enable
pc  output  16  current PC register value
ifid_instr  output  16  IF/ID instruction
ifid_pc_plus2  output  16  IF/ID PC+2 of that instruction, used by PCS and branches
ifid_valid  output  1  IF/ID holds a real instruction
fetch_halted  output  1  HLT fetched, fetch frozen

Behaviour:
- Reset (rst_n=0, async, any time including mid-stall/halt): pc=RESET_PC, ifid_instr=NOP_INSTR, ifid_pc_plus2=16'h0000, ifid_valid=0, fetch_halted=0. First fetch happens in the first cycle after deassertion.
- imem_addr=pc, combinational. imem_en = rst_n & ~fetch_halted.
- Fetched opcode is imem_data[15:12]. is_hlt = (opcode==HLT_OPCODE).
- Next-state priority is per rising edge, highest first.
  - 1. redirect=1:
    - pc <= redirect_pc.
    - ifid_valid <= 0 and ifid_instr <= NOP_INSTR. ifid_pc_plus2 is don't-care; drive 0.
    - fetch_halted <= 0, because an HLT behind a taken branch is wrong-path.
    - redirect overrides stall in the same cycle.
  - 2. stall=1: pc, IF/ID and fetch_halted all hold.
  - 3. fetch_halted=1:
    - pc holds.
    - IF/ID loads a bubble (valid=0, NOP_INSTR).
  - 4. Normal fetch, is_hlt=0:
    - pc <= pc+16'd2, wrapping mod 2^16 (16'hFFFE -> 16'h0000).
    - ifid_instr <= imem_data, ifid_pc_plus2 <= pc+2, ifid_valid <= 1.
  - 5. Normal fetch, is_hlt=1:
    - IF/ID loads the HLT with valid=1 and ifid_pc_plus2=pc+2, so the HLT travels down the pipe exactly once.
    - pc holds at the HLT address.
    - fetch_halted <= 1.
- Latency: an instruction at address A appears on ifid_instr one cycle after pc==A with no stall or redirect.
- An HLT that is fetched while stall=1 is not acted on until the stall drops, at which point it is refetched.
- fetch_halted is sticky. Only redirect or reset clears it.
- There is no handshake on imem. Memory is assumed zero-wait, and stall is the only backpressure.

Test Plan:
- Reset then free-run with imem returning 16'h1234 at 0, 16'h5678 at 2, 16'hABCD at 4 -> pc goes 0,2,4,6. IF/ID shows {1234,pc+2=2,v=1}, then {5678,4,1}, then {ABCD,6,1}, each one cycle after its pc.
- Stall asserted for 3 cycles at pc=4 -> pc stays 4 and the IF/ID contents hold for 3 cycles. Fetch resumes at 4 after the stall drops.
- Redirect and stall both 1 with redirect_pc=16'h0040 -> next pc=0x40, ifid_valid=0, ifid_instr=NOP_INSTR. Next cycle fetches from 0x40.
- HLT word 16'hF000 at pc=8 -> IF/ID gets {F000,10,1} once. fetch_halted=1, imem_en=0, pc stuck at 8, and ifid_valid=0 every cycle after.
- While halted, redirect with redirect_pc=0x20 -> fetch_halted=0, pc=0x20, and normal fetch resumes.
- pc=16'hFFFE with normal fetch -> next pc=16'h0000 and ifid_pc_plus2=16'h0000. Pulsing rst_n low mid-stall asynchronously returns all outputs to their reset values with no clock edge.

Source files
------------

// File: rtl/if_stage.sv
// if_stage: instruction-fetch stage of the 5-stage pipeline.
//   Owns the PC, drives a zero-wait instruction memory, and registers each
//   fetched word into IF/ID. Handles hazard stalls, execute-stage redirects
//   and HLT detection (fetch freezes until a redirect or reset).
// Ports:
//   clk, rst_n          clock (rising edge), async active-low reset
//   stall               hold PC, IF/ID and halt flag
//   redirect/_pc        taken branch: flush IF/ID, load redirect_pc
//   imem_data           combinational read data at imem_addr
//   imem_addr/imem_en   fetch address (= pc) / memory enable
//   pc                  current PC
//   ifid_*              IF/ID register: instruction, PC+2, valid
//   fetch_halted        HLT fetched, fetch frozen
module if_stage #(
  parameter logic [15:0] RESET_PC   = 16'h0000,
  parameter logic [15:0] NOP_INSTR  = 16'h0000,
  parameter logic [3:0]  HLT_OPCODE = 4'hF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  input  logic [15:0] imem_data,
  output logic [15:0] imem_addr,
  output logic        imem_en,
  output logic [15:0] pc,
  output logic [15:0] ifid_instr,
  output logic [15:0] ifid_pc_plus2,
  output logic        ifid_valid,
  output logic        fetch_halted
);

  logic [15:0] pc_q, pc_d;
  logic [15:0] instr_q, instr_d;
  logic [15:0] pp2_q, pp2_d;
  logic        valid_q, valid_d;
  logic        halted_q, halted_d;

  logic [15:0] pc_plus2;
  logic        is_hlt;

  assign pc_plus2 = pc_q + 16'd2;   // wraps naturally at 16 bits
  assign is_hlt   = (imem_data[15:12] == HLT_OPCODE);

  always_comb begin
    pc_d     = pc_q;
    instr_d  = instr_q;
    pp2_d    = pp2_q;
    valid_d  = valid_q;
    halted_d = halted_q;
    if (redirect) begin
      // Redirect beats stall; an HLT behind the branch is wrong-path.
      pc_d     = redirect_pc;
      instr_d  = NOP_INSTR;
      pp2_d    = 16'h0000;
      valid_d  = 1'b0;
      halted_d = 1'b0;
    end else if (stall) begin
      // hold everything
    end else if (halted_q) begin
      instr_d  = NOP_INSTR;
      pp2_d    = 16'h0000;
      valid_d  = 1'b0;
    end else begin
      instr_d  = imem_data;
      pp2_d    = pc_plus2;
      valid_d  = 1'b1;
      // HLT goes down the pipe once; PC parks on it.
      if (is_hlt) halted_d = 1'b1;
      else        pc_d     = pc_plus2;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q     <= RESET_PC;
      instr_q  <= NOP_INSTR;
      pp2_q    <= 16'h0000;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      pp2_q    <= pp2_d;
      valid_q  <= valid_d;
      halted_q <= halted_d;
    end
  end

  assign imem_addr     = pc_q;
  assign imem_en       = rst_n & ~halted_q;
  assign pc            = pc_q;
  assign ifid_instr    = instr_q;
  assign ifid_pc_plus2 = pp2_q;
  assign ifid_valid    = valid_q;
  assign fetch_halted  = halted_q;

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed scenarios with spec-given values, then a
// randomized run against a behavioural fetch model.
module tb_if_stage;
  logic        clk = 1'b0;
  logic        rst_n, stall, redirect;
  logic [15:0] redirect_pc, imem_data, imem_addr, pc;
  logic [15:0] ifid_instr, ifid_pc_plus2;
  logic        imem_en, ifid_valid, fetch_halted;

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] mem [0:255];
  assign imem_data = mem[imem_addr[8:1]];

  always #5 clk = ~clk;

  if_stage dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .imem_data(imem_data), .imem_addr(imem_addr),
    .imem_en(imem_en), .pc(pc), .ifid_instr(ifid_instr),
    .ifid_pc_plus2(ifid_pc_plus2), .ifid_valid(ifid_valid),
    .fetch_halted(fetch_halted)
  );

  // Observed state; pc_plus2 only matters while IF/ID is valid.
  logic [66:0] obs;
  assign obs = {imem_addr, pc, ifid_instr, (ifid_valid ? ifid_pc_plus2 : 16'h0),
                ifid_valid, fetch_halted, imem_en};

  logic [66:0] exp;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 16'h0;
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    #2;
    exp = {16'h0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0};
    n_tests++;
    if (obs !== exp) begin n_fail++; $display("FAIL reset got=%h exp=%h", obs, exp); end
    @(negedge clk) rst_n = 1'b1;
    #1;
    exp = {16'h0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1};
    n_tests++;
    if (obs !== exp) begin n_fail++; $display("FAIL reset_release got=%h exp=%h", obs, exp); end
  endtask

  // Free-run 0,2,4 then a 3-cycle stall at pc=4.
  task automatic test_freerun_stall();
    mem[0] = 16'h1234; mem[1] = 16'h5678; mem[2] = 16'hABCD; mem[3] = 16'h0777;
    tick();
    exp = {16'h2, 16'h2, 16'h1234, 16'h2, 1'b1, 1'b0, 1'b1};
    n_tests++;
    if (obs !== exp) begin n_fail++; $display("FAIL freerun_c1 got=%h exp=%h", obs, exp); end
    tick();
    exp = {16'h4, 16'h4, 16'h5678, 16'h4, 1'b1, 1'b0, 1'b1};
    n_tests++;
    if (obs !== exp) begin n_fail++; $display("FAIL freerun_c2 got=%h exp=%h", obs, exp); end
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_tests++;
      if (obs !== exp) begin n_fail++; $display("FAIL stall_hold%0d got=%h exp=%h", i, obs, exp); end
    end
    stall = 1'b0;
    tick();
    exp = {16'h6, 16'h6, 16'hABCD, 16'h6, 1'b1, 1'b0, 1'b1};
    n_tests++;
    if (obs !== exp) begin n_fail++; $display("FAIL stall_resume got=%h exp=%h", obs, exp); end
  endtask

  task automatic test_redirect_over_stall();
    mem[8'h20] = 16'h1111;
    stall = 1'b1; redirect = 1'b1; redirect_pc = 16'h0040;
    tick();
    exp = {16'h40, 16'h40, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1};
    n_tests++;
    if (obs !== exp) begin n_fail++; $display("FAIL redirect_stall got=%h exp=%h", obs, exp); end
    stall = 1'b0; redirect = 1'b0;
    tick();
    exp = {16'h42, 16'h42, 16'h1111, 16'h42, 1'b1, 1'b0, 1'b1};
    n_tests++;
    if (obs !== exp) begin n_fail++; $display("FAIL redirect_fetch got=%h exp=%h", obs, exp); end
  endtask

  task automatic test_halt();
    mem[4] = 16'hF000; mem[8'h10] = 16'h2222;
    redirect = 1'b1; redirect_pc = 16'h0008;
    tick();
    redirect = 1'b0;
    tick();
    exp = {16'h8, 16'h8, 16'hF000, 16'hA, 1'b1, 1'b1, 1'b0};
    n_tests++;
    if (obs !== exp) begin n_fail++; $display("FAIL halt_fetch got=%h exp=%h", obs, exp); end
    exp = {16'h8, 16'h8, 16'h0, 16'h0, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 3; i++) begin
      tick();
      n_tests++;
      if (obs !== exp) begin n_fail++; $display("FAIL halt_frozen%0d got=%h exp=%h", i, obs, exp); end
    end
    redirect = 1'b1; redirect_pc = 16'h0020;
    tick();
    exp = {16'h20, 16'h20, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1};
    n_tests++;
    if (obs !== exp) begin n_fail++; $display("FAIL halt_redirect got=%h exp=%h", obs, exp); end
    redirect = 1'b0;
    tick();
    exp = {16'h22, 16'h22, 16'h2222, 16'h22, 1'b1, 1'b0, 1'b1};
    n_tests++;
    if (obs !== exp) begin n_fail++; $display("FAIL halt_resume got=%h exp=%h", obs, exp); end
  endtask

  task automatic test_wrap();
    mem[255] = 16'h3333;
    redirect = 1'b1; redirect_pc = 16'hFFFE;
    tick();
    redirect = 1'b0;
    tick();
    exp = {16'h0, 16'h0, 16'h3333, 16'h0, 1'b1, 1'b0, 1'b1};
    n_tests++;
    if (obs !== exp) begin n_fail++; $display("FAIL pc_wrap got=%h exp=%h", obs, exp); end
  endtask

  task automatic test_async_reset();
    stall = 1'b1;
    tick();
    #2 rst_n = 1'b0;
    #1;
    exp = {16'h0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0};
    n_tests++;
    if (obs !== exp) begin n_fail++; $display("FAIL async_reset got=%h exp=%h", obs, exp); end
    n_tests++;
    if (ifid_pc_plus2 !== 16'h0) begin
      n_fail++; $display("FAIL async_reset_pp2 got=%h exp=0000", ifid_pc_plus2);
    end
    @(negedge clk) begin rst_n = 1'b1; stall = 1'b0; end
  endtask

  // Behavioural model: state of the fetch stage as plain variables.
  task automatic test_random();
    logic [15:0] m_pc, m_instr, m_pp2, w;
    logic        m_v, m_h, s, r;
    logic [15:0] rp;
    for (int i = 0; i < 256; i++)
      mem[i] = ($urandom_range(0, 7) == 0) ? {4'hF, 12'($urandom)} : 16'($urandom);
    // state is at reset values after test_async_reset
    m_pc = 16'h0; m_instr = 16'h0; m_pp2 = 16'h0; m_v = 1'b0; m_h = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      s  = ($urandom_range(0, 3) == 0);
      r  = ($urandom_range(0, 11) == 0);
      rp = {15'($urandom), 1'b0};
      stall = s; redirect = r; redirect_pc = rp;
      w = mem[m_pc[8:1]];
      tick();
      if (r) begin
        m_pc = rp; m_instr = 16'h0; m_v = 1'b0; m_h = 1'b0;
      end else if (s) begin
      end else if (m_h) begin
        m_instr = 16'h0; m_v = 1'b0;
      end else begin
        m_instr = w; m_pp2 = m_pc + 16'd2; m_v = 1'b1;
        if (w[15:12] == 4'hF) m_h = 1'b1;
        else m_pc = m_pc + 16'd2;
      end
      exp = {m_pc, m_pc, m_instr, (m_v ? m_pp2 : 16'h0), m_v, m_h, ~m_h};
      n_tests++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL random_cyc%0d got=%h exp=%h", c, obs, exp);
      end
    end
    stall = 1'b0; redirect = 1'b0;
  endtask

  initial begin
    test_reset();
    test_freerun_stall();
    test_redirect_over_stall();
    test_halt();
    test_wrap();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
